// File: rtl/fixed_latency_issuer_if.sv
// dti: valid/ready data stream between producer and consumer.
// Only the consumer side is used by fixed_latency_issuer.
interface dti #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport consumer (
    input  data,
    input  valid,
    output ready
  );

  modport producer (
    output data,
    output valid,
    input  ready
  );
endinterface

// File: rtl/fixed_latency_issuer.sv
// fixed_latency_issuer: credit-gated issue into a fixed-latency pipe.
// Optional stall counter: define FIXED_LATENCY_ISSUER_STALL_CNT_EN.
module fixed_latency_issuer #(
  parameter  int DATA_W  = 16,
  parameter  int LATENCY = 3,
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1),
  localparam int IW      = $clog2(LATENCY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dti.consumer              din,
  output logic              issue_valid,
  output logic [DATA_W-1:0] issue_data,
  input  logic              credit_ret,
  input  logic              flush,
  output logic              flush_done,
  output logic [CW-1:0]     credits,
  output logic [IW-1:0]     inflight,
  output logic              credit_err
`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t             state;
  logic [LATENCY-1:0] pipe;
  logic [LATENCY:0]   pipe_nx;
  logic               pipe_exit;
  logic               hs;
  logic               cred_full;
  logic               drained;

  assign din.ready = !rst && (state == RUN)
                     && (credits != '0);
  assign hs        = din.valid && din.ready;
  assign cred_full = credits == CW'(CREDITS);
  assign pipe_nx   = {pipe, issue_valid};
  assign pipe_exit = pipe[LATENCY-1];
  assign drained   = (inflight == '0) && !issue_valid;

  // Drain completes in the cycle nothing is left in flight.
  assign flush_done = !rst && (state == DRAIN) && drained;

  // Issue register: one-cycle strobe, data held between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
    end else begin
      issue_valid <= hs;
      if (hs)
        issue_data <= din.data;
    end
  end

  // Credit pool; a return into a full pool is an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else if (credit_ret && !hs && cred_full) begin
      credit_err <= 1'b1;
    end else if (hs && !credit_ret) begin
      credits <= credits - CW'(1);
    end else if (!hs && credit_ret) begin
      credits <= credits + CW'(1);
    end
  end

  // Shadow of the downstream pipe and its occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe     <= '0;
      inflight <= '0;
    end else begin
      pipe <= pipe_nx[LATENCY-1:0];
      unique case ({issue_valid, pipe_exit})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // RUN accepts work; DRAIN waits for the pipe to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:     if (flush)   state <= DRAIN;
        DRAIN:   if (drained) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
  // Cycles the producer was held off.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (din.valid && !din.ready)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fixed_latency_issuer.sv
// tb_fixed_latency_issuer: directed and random checks
// against a cycle-indexed reference model.
module tb_fixed_latency_issuer;
  localparam int DW = 16;
  localparam int L  = 3;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          credit_ret;
  logic          flush;
  logic          issue_valid;
  logic [DW-1:0] issue_data;
  logic          flush_done;
  logic [2:0]    credits;
  logic [1:0]    inflight;
  logic          credit_err;
  logic [31:0]   stall_val;
`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
  logic [31:0]   stall_cnt;
  assign stall_val = stall_cnt;
`else
  assign stall_val = '0;
`endif

  dti #(.DATA_W(DW)) din ();

  fixed_latency_issuer #(
    .DATA_W (DW),
    .LATENCY(L),
    .CREDITS(C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .issue_valid(issue_valid),
    .issue_data (issue_data),
    .credit_ret (credit_ret),
    .flush      (flush),
    .flush_done (flush_done),
    .credits    (credits),
    .inflight   (inflight),
    .credit_err (credit_err)
`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  bit            chk_en = 0;
  int            cyc = 0;
  int            fd_seen = 0;
  int            m_cred;
  bit            m_err;
  bit            m_drain;
  bit            m_iv;
  logic [DW-1:0] m_idata;
  logic [31:0]   m_stall;
  int            hq[$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues are in flight from 2 to L+1 cycles after handshake.
  function automatic int m_inflight();
    int n = 0;
    foreach (hq[i])
      if (hq[i] + 2 <= cyc && cyc <= hq[i] + 1 + L) n++;
    return n;
  endfunction

  task automatic step(bit v, logic [DW-1:0] d, bit cr,
                      bit fl, bit r);
    bit m_rdy;
    bit hs;
    bit fd;
    int inf;
    @(negedge clk);
    din.valid  = v;
    din.data   = d;
    credit_ret = cr;
    flush      = fl;
    rst        = r;
    #1;
    inf   = m_inflight();
    m_rdy = !r && !m_drain && m_cred != 0;
    hs    = v && m_rdy;
    fd    = !r && m_drain && inf == 0 && !m_iv;
    if (flush_done === 1'b1) fd_seen++;
    if (chk_en) begin
      chk("ready", 32'(din.ready), 32'(m_rdy));
      chk("issue_valid", 32'(issue_valid), 32'(m_iv));
      chk("issue_data", 32'(issue_data), 32'(m_idata));
      chk("credits", 32'(credits), 32'(m_cred));
      chk("inflight", 32'(inflight), 32'(inf));
      chk("credit_err", 32'(credit_err), 32'(m_err));
      chk("flush_done", 32'(flush_done), 32'(fd));
`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
      chk("stall_cnt", stall_val, m_stall);
`endif
    end
    if (r) begin
      m_cred  = C;
      m_err   = 0;
      m_drain = 0;
      m_iv    = 0;
      m_idata = '0;
      m_stall = '0;
      hq.delete();
    end else begin
      if (cr && !hs && m_cred == C) m_err = 1;
      else m_cred = m_cred - int'(hs) + int'(cr);
      if (v && !m_rdy) m_stall = m_stall + 32'd1;
      m_iv = hs;
      if (hs) begin
        m_idata = d;
        hq.push_back(cyc);
      end
      if (!m_drain && fl) m_drain = 1;
      else if (m_drain && fd) m_drain = 0;
    end
    cyc++;
    while (hq.size() > 0 && hq[0] + 1 + L < cyc)
      void'(hq.pop_front());
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
  endtask

  initial begin
    din.valid  = 0;
    din.data   = '0;
    credit_ret = 0;
    flush      = 0;
    rst        = 1;
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    chk_en = 1;
    step(0, '0, 0, 0, 0);
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_data", 32'(issue_data), 32'd0);

    // credit exhaustion
    for (int k = 1; k <= 6; k++) step(1, DW'(k), 0, 0, 0);
    post();
    chk("exh_credits", 32'(credits), 32'd0);
    chk("exh_data", 32'(issue_data), 32'd4);
    chk("exh_ready", 32'(din.ready), 32'd0);

    // single credit return
    step(1, 16'd5, 1, 0, 0);
    step(1, 16'd5, 0, 0, 0);
    post();
    chk("ret_data", 32'(issue_data), 32'd5);
    chk("ret_valid", 32'(issue_valid), 32'd1);
    chk("ret_credits", 32'(credits), 32'd0);
    idle(6);

    // handshake coincident with credit return
    do_reset();
    step(1, 16'h11, 0, 0, 0);
    step(1, 16'h22, 0, 0, 0);
    step(1, 16'h33, 1, 0, 0);
    post();
    chk("coin_credits", 32'(credits), 32'd2);
    chk("coin_err", 32'(credit_err), 32'd0);
    idle(6);

    // flush after two issues
    do_reset();
    step(1, 16'hA1, 0, 0, 0);
    step(1, 16'hA2, 0, 0, 0);
    fd_seen = 0;
    step(0, '0, 0, 1, 0);
    post();
    chk("fl_ready", 32'(din.ready), 32'd0);
    idle(8);
    chk("fl_pulses", 32'(fd_seen), 32'd1);

    // flush with nothing in flight
    fd_seen = 0;
    step(0, '0, 0, 1, 0);
    idle(3);
    chk("fl0_pulses", 32'(fd_seen), 32'd1);

    // overflow is sticky
    do_reset();
    step(0, '0, 1, 0, 0);
    post();
    chk("ovf_credits", 32'(credits), 32'd4);
    chk("ovf_err", 32'(credit_err), 32'd1);
    idle(4);
    do_reset();
    chk("ovf_clear", 32'(credit_err), 32'd0);

`ifdef FIXED_LATENCY_ISSUER_STALL_CNT_EN
    for (int k = 0; k < 4; k++) step(1, DW'(k), 0, 0, 0);
    for (int k = 0; k < 10; k++) step(1, DW'(k), 0, 0, 0);
    post();
    chk("stall10", stall_val, 32'd10);
    step(0, '0, 0, 0, 1);
    post();
    chk("stall_rst", stall_val, 32'd0);
    chk("stall_rst_cr", 32'(credits), 32'd4);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 3) != 0),
           DW'($urandom),
           bit'($urandom_range(0, 9) < 3),
           bit'($urandom_range(0, 19) == 0),
           bit'($urandom_range(0, 99) == 0));
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
